// File: rtl/riscv_data_bus_decoder_if.sv
// Data-bus bundle between the LSU master port, the address decoder and the
// N_SLAVES slave ports. Slave k read data sits at s_rd_i[32k+31:32k].
interface riscv_data_bus_decoder_if #(
  parameter int unsigned N_SLAVES = 8
) ();

  // Master side
  logic                      m_req_i;
  logic                      m_we_i;
  logic [3:0]                m_be_i;
  logic [31:0]               m_addr_i;
  logic [31:0]               m_wd_i;
  logic [31:0]               m_rd_o;
  logic                      m_ready_o;
  logic                      m_err_o;

  // Slave side
  logic [N_SLAVES-1:0]       s_req_o;
  logic                      s_we_o;
  logic [3:0]                s_be_o;
  logic [31:0]               s_addr_o;
  logic [31:0]               s_wd_o;
  logic [32*N_SLAVES-1:0]    s_rd_i;
  logic [N_SLAVES-1:0]       s_ready_i;

  // LSU view
  modport master (
    output m_req_i, m_we_i, m_be_i, m_addr_i, m_wd_i,
    input  m_rd_o, m_ready_o, m_err_o
  );

  // Slave devices' view
  modport slave (
    input  s_req_o, s_we_o, s_be_o, s_addr_o, s_wd_o,
    output s_rd_i, s_ready_i
  );

  // Decoder view: sits between master and slaves
  modport decoder (
    input  m_req_i, m_we_i, m_be_i, m_addr_i, m_wd_i,
    output m_rd_o, m_ready_o, m_err_o,
    output s_req_o, s_we_o, s_be_o, s_addr_o, s_wd_o,
    input  s_rd_i, s_ready_i
  );

endinterface

// File: rtl/riscv_data_bus_decoder.sv
// Data-bus decoder: routes one LSU master to N_SLAVES slaves selected by
// address bits [31:24]. Tracks multi-cycle ready per transaction, returns a
// bus error for unmapped addresses or unresponsive slaves, and counts errors.
module riscv_data_bus_decoder #(
  parameter int unsigned          N_SLAVES   = 8,
  parameter logic [N_SLAVES-1:0]  SLAVE_MASK = '1,
  parameter int unsigned          TIMEOUT    = 16,
  parameter logic [31:0]          ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                              clk_i,
  input  logic                              resetn_i,
  riscv_data_bus_decoder_if.decoder         bus,
  output logic [15:0]                       err_cnt_o,
  output logic [31:0]                       err_addr_o
);

  localparam int unsigned CntW = ($clog2(TIMEOUT) < 1) ? 1 : $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  // Presence mask widened to the full 8-bit selector range; indices at or
  // above N_SLAVES read as absent.
  localparam logic [255:0] MaskExt = 256'(SLAVE_MASK);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StErr  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [7:0]      sel_q, sel_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     err_cnt_q, err_cnt_d;
  logic [31:0]     err_addr_q, err_addr_d;

  logic [7:0]      idx;
  logic            mapped;
  logic [7:0]      cur;
  logic [31:0]     rd_cur;
  logic            ready_cur;
  logic            req_active;
  logic            complete;
  logic            err_rsp;
  logic            log_err;

  assign idx    = bus.m_addr_i[31:24];
  assign mapped = MaskExt[idx];
  // Slave currently addressed: live selector in IDLE, latched one in BUSY.
  assign cur    = (state_q == StBusy) ? sel_q : idx;

  // Read-data / ready mux for the addressed slave
  always_comb begin
    rd_cur    = 32'd0;
    ready_cur = 1'b0;
    for (int k = 0; k < int'(N_SLAVES); k++) begin
      if (cur == 8'(k)) begin
        rd_cur    = bus.s_rd_i[32*k +: 32];
        ready_cur = bus.s_ready_i[k];
      end
    end
  end

  // Request is forwarded only while a mapped transaction is live
  assign req_active = resetn_i && bus.m_req_i &&
                      (((state_q == StIdle) && mapped) || (state_q == StBusy));

  // One-hot slave request
  always_comb begin
    bus.s_req_o = '0;
    for (int k = 0; k < int'(N_SLAVES); k++) begin
      bus.s_req_o[k] = req_active && (cur == 8'(k));
    end
  end

  // Next-state, response and error-bookkeeping logic
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    complete   = 1'b0;
    err_rsp    = 1'b0;
    log_err    = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.m_req_i) begin
          if (!mapped) begin
            state_d = StErr;
            log_err = 1'b1;
          end else if (ready_cur) begin
            complete = 1'b1;
          end else begin
            sel_d   = idx;
            cnt_d   = CntW'(1);
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (!bus.m_req_i) begin
          // Master abort: drop the slave request without a response
          state_d = StIdle;
          cnt_d   = '0;
        end else if (ready_cur) begin
          complete = 1'b1;
          state_d  = StIdle;
          cnt_d    = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StErr;
          cnt_d   = '0;
          log_err = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StErr: begin
        // Single-cycle error response; slave ready is ignored here
        err_rsp = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    if (log_err) begin
      err_addr_d = bus.m_addr_i;
      if (err_cnt_q != 16'hFFFF) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end
    end
  end

  // Master response and slave broadcast; everything forced low during reset
  always_comb begin
    bus.m_ready_o = resetn_i && (complete || err_rsp);
    bus.m_err_o   = resetn_i && err_rsp;
    if (!resetn_i) begin
      bus.m_rd_o = 32'd0;
    end else if (err_rsp) begin
      bus.m_rd_o = ERR_DATA;
    end else if (complete) begin
      bus.m_rd_o = rd_cur;
    end else begin
      bus.m_rd_o = 32'd0;
    end
    bus.s_we_o   = resetn_i && bus.m_we_i;
    bus.s_be_o   = resetn_i ? bus.m_be_i : 4'd0;
    bus.s_addr_o = resetn_i ? {8'd0, bus.m_addr_i[23:0]} : 32'd0;
    bus.s_wd_o   = resetn_i ? bus.m_wd_i : 32'd0;
  end

  // State and error registers
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= StIdle;
      sel_q      <= 8'd0;
      cnt_q      <= '0;
      err_cnt_q  <= 16'd0;
      err_addr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign err_cnt_o  = err_cnt_q;
  assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_riscv_data_bus_decoder.sv
// Randomised bench for riscv_data_bus_decoder with a transaction-level model.
module tb_riscv_data_bus_decoder;

  localparam int unsigned     NS   = 8;
  localparam logic [NS-1:0]   MASK = 8'b1111_1101;
  localparam int              TO   = 16;
  localparam logic [31:0]     ED   = 32'hDEAD_BEEF;

  logic        clk_i    = 1'b0;
  logic        resetn_i = 1'b1;
  logic [15:0] err_cnt;
  logic [31:0] err_addr;

  riscv_data_bus_decoder_if #(.N_SLAVES(NS)) bus ();

  riscv_data_bus_decoder #(
    .N_SLAVES   (NS),
    .SLAVE_MASK (MASK),
    .TIMEOUT    (TO),
    .ERR_DATA   (ED)
  ) dut (
    .clk_i      (clk_i),
    .resetn_i   (resetn_i),
    .bus        (bus),
    .err_cnt_o  (err_cnt),
    .err_addr_o (err_addr)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  logic          cmp_en = 1'b0;
  logic [NS-1:0] exp_sreq;
  logic          exp_ready, exp_err, exp_we;
  logic [31:0]   exp_rd, exp_addr, exp_wd, exp_erraddr;
  logic [3:0]    exp_be;
  logic [15:0]   exp_errcnt;

  int            model_err_cnt  = 0;
  logic [31:0]   model_err_addr = 32'd0;
  logic [31:0]   words [NS];

  int            cur_c = 0;
  int            resp_c = -1;
  logic          resp_seen = 1'b0;
  logic [31:0]   last_rd = 32'd0;
  logic          last_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk_i) begin
    if (cmp_en) begin
      check("s_req",    32'(bus.s_req_o),   32'(exp_sreq));
      check("m_ready",  32'(bus.m_ready_o), 32'(exp_ready));
      check("m_err",    32'(bus.m_err_o),   32'(exp_err));
      check("m_rd",     bus.m_rd_o,         exp_rd);
      check("s_addr",   bus.s_addr_o,       exp_addr);
      check("s_we",     32'(bus.s_we_o),    32'(exp_we));
      check("s_be",     32'(bus.s_be_o),    32'(exp_be));
      check("s_wd",     bus.s_wd_o,         exp_wd);
      check("err_cnt",  32'(err_cnt),       32'(exp_errcnt));
      check("err_addr", err_addr,           exp_erraddr);
      if (bus.m_ready_o === 1'b1) begin
        resp_seen = 1'b1;
        resp_c    = cur_c;
        last_rd   = bus.m_rd_o;
        last_err  = bus.m_err_o;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Pass-through fields and error registers follow directly from inputs/model
  task automatic set_pass();
    exp_we      = resetn_i & bus.m_we_i;
    exp_be      = resetn_i ? bus.m_be_i : 4'd0;
    exp_addr    = resetn_i ? {8'h00, bus.m_addr_i[23:0]} : 32'd0;
    exp_wd      = resetn_i ? bus.m_wd_i : 32'd0;
    exp_errcnt  = 16'(model_err_cnt);
    exp_erraddr = model_err_addr;
  endtask

  task automatic drive_words();
    for (int k = 0; k < int'(NS); k++) begin
      words[k] = $urandom;
      bus.s_rd_i[32*k +: 32] = words[k];
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.m_req_i   = 1'b0;
      bus.m_we_i    = 1'($urandom);
      bus.m_be_i    = 4'($urandom);
      bus.m_addr_i  = $urandom;
      bus.m_wd_i    = $urandom;
      bus.s_ready_i = NS'($urandom);
      drive_words();
      exp_sreq = '0; exp_ready = 1'b0; exp_err = 1'b0; exp_rd = 32'd0;
      set_pass();
      tick();
    end
  endtask

  // One master transaction. lat: cycle the target slave asserts ready
  // (>= TO means silent, TO itself gives a late ready). abort_at / rst_at < 0
  // disable those events.
  task automatic run_txn(input logic [7:0] idx, input logic [23:0] low, input logic we,
                         input int lat, input int abort_at, input int rst_at,
                         input logic [31:0] tgt_rd);
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        mapped;
    logic        done;
    int          c;
    addr   = {idx, low};
    be     = 4'($urandom);
    wd     = $urandom;
    mapped = (int'(idx) < int'(NS)) && (((int'(MASK) >> idx) & 1) == 1);
    resp_seen = 1'b0;
    done = 1'b0;
    c = 0;
    while (!done) begin
      cur_c         = c;
      bus.m_req_i   = !(abort_at >= 0 && c == abort_at);
      bus.m_we_i    = we;
      bus.m_be_i    = be;
      bus.m_addr_i  = addr;
      bus.m_wd_i    = wd;
      drive_words();
      bus.s_ready_i = NS'($urandom);
      if (mapped) begin
        words[idx[2:0]] = tgt_rd;
        bus.s_rd_i[32*int'(idx) +: 32] = tgt_rd;
        bus.s_ready_i[idx[2:0]] = (c == lat);
      end
      exp_sreq = '0; exp_ready = 1'b0; exp_err = 1'b0; exp_rd = 32'd0;
      if (rst_at >= 0 && c == rst_at) begin
        resetn_i       = 1'b0;
        model_err_cnt  = 0;
        model_err_addr = 32'd0;
        done = 1'b1;
      end else if (!mapped) begin
        if (c == 1) begin
          exp_ready = 1'b1; exp_err = 1'b1; exp_rd = ED;
          done = 1'b1;
        end
      end else if (abort_at >= 0 && c == abort_at) begin
        done = 1'b1;
      end else if (c <= TO - 1) begin
        exp_sreq = NS'(1) << idx;
        if (c == lat) begin
          exp_ready = 1'b1;
          exp_rd    = tgt_rd;
          done      = 1'b1;
        end
      end else begin
        exp_ready = 1'b1; exp_err = 1'b1; exp_rd = ED;
        done = 1'b1;
      end
      // Error bookkeeping is already visible in the error-response cycle
      if (exp_err) begin
        if (model_err_cnt < 65535) model_err_cnt++;
        model_err_addr = addr;
      end
      set_pass();
      tick();
      c++;
      if (c > TO + 4) begin
        check("txn_bound", 32'(c), 32'(TO + 4));
        done = 1'b1;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.m_req_i = 1'b0; bus.m_we_i = 1'b0; bus.m_be_i = 4'd0;
    bus.m_addr_i = 32'd0; bus.m_wd_i = 32'd0;
    bus.s_rd_i = '0; bus.s_ready_i = '0;
    exp_sreq = '0; exp_ready = 1'b0; exp_err = 1'b0; exp_rd = 32'd0;
    #1;
    resetn_i = 1'b0;
    set_pass();
    cmp_en = 1'b1;
    tick();
    check("reset_errcnt", 32'(err_cnt), 32'd0);
    resetn_i = 1'b1;
    idle(2);

    // Zero-wait read of slave 0
    run_txn(8'h00, 24'h000010, 1'b0, 0, -1, -1, 32'h1234_5678);
    check("zw_seen",  32'(resp_seen), 32'd1);
    check("zw_cycle", 32'(resp_c),    32'd0);
    check("zw_rd",    last_rd,        32'h1234_5678);
    check("zw_ecnt",  32'(err_cnt),   32'd0);

    // Wait-state write to slave 3, ready 3 cycles later
    run_txn(8'h03, 24'h000004, 1'b1, 3, -1, -1, $urandom);
    check("ws_cycle", 32'(resp_c),   32'd3);
    check("ws_err",   32'(last_err), 32'd0);

    // Unmapped selectors, including the first index past the last slave
    run_txn(8'h09, 24'h000000, 1'b0, 0, -1, -1, $urandom);
    check("um_cycle", 32'(resp_c),   32'd1);
    check("um_rd",    last_rd,       32'hDEAD_BEEF);
    check("um_err",   32'(last_err), 32'd1);
    check("um_ecnt",  32'(err_cnt),  32'd1);
    check("um_eaddr", err_addr,      32'h0900_0000);
    run_txn(8'h08, 24'h0000AC, 1'b1, 0, -1, -1, $urandom);
    check("um8_ecnt", 32'(err_cnt), 32'd2);
    run_txn(8'h07, 24'h000100, 1'b0, 1, -1, -1, $urandom);
    check("s7_cycle", 32'(resp_c), 32'd1);

    // Silent slave 2 with a late ready in the error cycle
    run_txn(8'h02, 24'h000040, 1'b0, TO, -1, -1, $urandom);
    check("to_cycle", 32'(resp_c),   32'd16);
    check("to_err",   32'(last_err), 32'd1);
    check("to_ecnt",  32'(err_cnt),  32'd3);
    check("to_eaddr", err_addr,      32'h0200_0040);

    // Masked slave 1 behaves as unmapped
    run_txn(8'h01, 24'h000000, 1'b0, 0, -1, -1, $urandom);
    check("mk_cycle", 32'(resp_c),  32'd1);
    check("mk_ecnt",  32'(err_cnt), 32'd4);

    // Last legal wait cycle
    run_txn(8'h04, 24'h000008, 1'b0, TO - 1, -1, -1, $urandom);
    check("l15_cycle", 32'(resp_c),   32'd15);
    check("l15_err",   32'(last_err), 32'd0);

    // Abort in BUSY
    run_txn(8'h05, 24'h000000, 1'b1, 99, 2, -1, $urandom);
    check("ab_noresp", 32'(resp_seen), 32'd0);
    idle(1);

    // Reset mid-BUSY, then a fresh request from IDLE
    run_txn(8'h06, 24'h000000, 1'b0, 99, -1, 3, $urandom);
    check("rst_ecnt",  32'(err_cnt), 32'd0);
    check("rst_eaddr", err_addr,     32'd0);
    resetn_i = 1'b1;
    idle(1);
    run_txn(8'h00, 24'h000020, 1'b0, 0, -1, -1, 32'hCAFE_0001);
    check("post_rst_cycle", 32'(resp_c), 32'd0);
    check("post_rst_rd",    last_rd,     32'hCAFE_0001);

    // Randomised traffic
    for (int t = 0; t < 300; t++) begin
      logic [7:0] ridx;
      int         rlat;
      int         rab;
      ridx = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
      rlat = $urandom_range(0, TO + 1);
      rab  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, TO - 1)) : -1;
      run_txn(ridx, 24'($urandom), 1'($urandom), rlat, rab, -1, $urandom);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end

    idle(1);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/riscv_data_bus_decoder.md
Name: riscv_data_bus_decoder

Overview:
- Parametrised data-bus interconnect between the LSU memory port (one master) and N_SLAVES data slaves: external memory plus peripheral controllers.
- Slave selection uses address bits [31:24]. Slaves see the address with the selector field zeroed.
- Adds what the fixed one-hot decode lacks: a multi-cycle ready handshake tracked per transaction, a bus-error response for unmapped addresses and for slaves that never respond, and error bookkeeping.

Parameters:
- N_SLAVES, 8: number of slave ports. Legal range 1..256.
- SLAVE_MASK, all-ones (N_SLAVES bits): bit k=1 marks slave k as present.
- TIMEOUT, 16: cycles allowed for a slave response, counting from the request cycle. Must be >= 2.
- ERR_DATA, 32'hDEAD_BEEF: read data returned with an error response.

Ports:
- clk_i  in  1  system clock
- resetn_i  in  1  asynchronous active-low reset
- m_req_i  in  1  master request; held with all fields stable until m_ready_o, or dropped to abort
- m_we_i  in  1  write enable
- m_be_i  in  4  byte enables
- m_addr_i  in  32  byte address
- m_wd_i  in  32  write data
- m_rd_o  out  32  read data, valid when m_ready_o=1
- m_ready_o  out  1  transaction-complete strobe, 1 cycle
- m_err_o  out  1  bus error, qualifies m_ready_o
- s_req_o  out  N_SLAVES  one-hot slave request
- s_we_o  out  1  broadcast write enable
- s_be_o  out  4  broadcast byte enables
- s_addr_o  out  32  {8'd0, m_addr_i[23:0]}
- s_wd_o  out  32  broadcast write data
- s_rd_i  in  32*N_SLAVES  slave k read data at bits [32k+31:32k]
- s_ready_i  in  N_SLAVES  slave completion strobes
- err_cnt_o  out  16  saturating bus-error count
- err_addr_o  out  32  full address of the most recent error

Behaviour:
- Definitions: idx = m_addr_i[31:24]. mapped = (idx < N_SLAVES) && SLAVE_MASK[idx].
- FSM states: IDLE, BUSY, ERR. Registers: state, sel (8 bits), cnt (ceil(log2 TIMEOUT) bits), err_cnt_o, err_addr_o.
- Reset (asynchronous, resetn_i=0):
  - state=IDLE, cnt=0, sel=0, err_cnt_o=0, err_addr_o=0.
  - All outputs 0; s_req_o=0 even if a transaction was in flight.
- IDLE, m_req_i=1 and mapped:
  - Combinational same cycle: s_req_o[idx]=1.
  - If s_ready_i[idx]=1 that cycle: m_ready_o=1, m_rd_o=s_rd_i[idx]. Stay IDLE (zero-wait slaves complete in 1 cycle).
  - Otherwise: sel<=idx, cnt<=1, go to BUSY.
- IDLE, m_req_i=1 and unmapped:
  - No s_req_o asserted. Go to ERR.
  - Latch err_addr_o<=m_addr_i. Increment err_cnt_o, saturating at 16'hFFFF.
- BUSY, m_req_i=1:
  - s_req_o[sel]=1.
  - If s_ready_i[sel]=1: m_ready_o=1, m_rd_o=s_rd_i[sel], go to IDLE.
  - Else if cnt==TIMEOUT-1: go to ERR, latch err_addr_o, increment err_cnt_o.
  - Else cnt<=cnt+1.
- BUSY, m_req_i=0 (abort):
  - s_req_o=0, no response, go to IDLE, cnt<=0.
- ERR:
  - Exactly 1 cycle: m_ready_o=1, m_err_o=1, m_rd_o=ERR_DATA, s_req_o=0. Go to IDLE.
  - Any s_ready_i asserted in this cycle is ignored.
- Latency:
  - Slave ready on cycle n (request issued cycle 0): m_ready_o on cycle n, for 0 <= n <= TIMEOUT-1.
  - Timeout error on cycle TIMEOUT.
  - Unmapped error on cycle 1.
- s_ready_i of non-selected slaves is always ignored. m_rd_o=0 whenever m_ready_o=0.
- Writes to unmapped addresses or timed-out writes get the same error response; s_we_o is never paired with an active s_req_o bit in these cases.
- s_we_o, s_be_o and s_wd_o pass m_* through combinationally at all times. Slaves qualify them with their s_req_o bit.
- Back-to-back: after m_ready_o, the master may present a new request on the next cycle (IDLE); no bubble is required.

Test Plan:
- Zero-wait read: slave 0 ready combinational, addr 32'h0000_0010, s_rd_i[31:0]=32'h1234_5678 -> m_ready_o=1 in cycle 0, m_rd_o=32'h1234_5678, s_addr_o=32'h10, err_cnt_o=0.
- Wait-state write: addr 32'h0300_0004, slave 3 ready 3 cycles later -> s_req_o=8'b0000_1000 for cycles 0..3, m_ready_o on cycle 3 only, m_err_o=0.
- Unmapped: N_SLAVES=4, addr 32'h0700_0000 -> s_req_o=0; cycle 1 m_ready_o=1, m_err_o=1, m_rd_o=32'hDEAD_BEEF; err_cnt_o=1, err_addr_o=32'h0700_0000.
- Timeout: TIMEOUT=16, slave 2 silent -> s_req_o[2]=1 for cycles 0..15, error response on cycle 16, err_cnt_o increments. A late s_ready_i[2] on cycle 16 is ignored.
- Masked slave: SLAVE_MASK=8'b1111_1101, access slave 1 -> treated as unmapped (error on cycle 1).
- Abort and reset: drop m_req_i in BUSY -> s_req_o=0 the same cycle, no m_ready_o. Assert resetn_i=0 mid-BUSY -> all outputs 0 immediately, err_cnt_o=0. The next request after reset behaves as from IDLE.
